// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RISC-X core types: register banks, memory access sizes, MEM-stage FSM states.
package core_pkg;

   typedef enum logic {
      X_REG = 1'b0,
      F_REG = 1'b1
   } reg_bank_mux_t;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      MEM_IDLE        = 2'b00,
      MEM_WAIT_RVALID = 2'b01,
      MEM_DONE        = 2'b10
   } mem_fsm_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for loads/stores: byte enables, store shift, load extract/extend, misalignment.
module lsu_align
   import core_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  mem_size_t   size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misaligned_o,
   output logic [31:0] rdata_o
);

   logic [31:0] rdata_shifted;

   assign rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};
   assign wdata_o       = wdata_i << {addr_lo_i, 3'b000};

   always_comb begin
      be_o         = 4'b1111;
      misaligned_o = 1'b0;
      rdata_o      = rdata_i;
      case (size_i)
         MEM_BYTE: begin
            be_o    = 4'b0001 << addr_lo_i;
            rdata_o = {{24{rdata_shifted[7] & ~unsigned_i}}, rdata_shifted[7:0]};
         end
         MEM_HALF: begin
            be_o         = 4'b0011 << addr_lo_i;
            misaligned_o = addr_lo_i[0];
            rdata_o      = {{16{rdata_shifted[15] & ~unsigned_i}}, rdata_shifted[15:0]};
         end
         default: begin
            misaligned_o = |addr_lo_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-X MEM stage: EX->MEM register, OBI-style data-memory access, stall/flush handling.
module mem_stage
   import core_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic [4:0]    rd_addr_ex_i,
   input  reg_bank_mux_t rd_dst_bank_ex_i,
   input  logic [31:0]   alu_result_ex_i,
   input  logic [31:0]   mem_wdata_ex_i,
   input  logic          mem_req_ex_i,
   input  logic          mem_we_ex_i,
   input  mem_size_t     mem_size_ex_i,
   input  logic          mem_unsigned_ex_i,
   input  logic          reg_alu_wen_ex_i,
   input  logic          reg_mem_wen_ex_i,
   input  logic          valid_ex_i,
   output logic [4:0]    rd_addr_mem_o,
   output reg_bank_mux_t rd_dst_bank_mem_o,
   output logic [31:0]   alu_result_mem_o,
   output logic [31:0]   mem_rdata_mem_o,
   output logic          reg_alu_wen_mem_o,
   output logic          reg_mem_wen_mem_o,
   output logic          valid_mem_o,
   output logic          dmem_req_o,
   input  logic          dmem_gnt_i,
   output logic [31:0]   dmem_addr_o,
   output logic          dmem_we_o,
   output logic [3:0]    dmem_be_o,
   output logic [31:0]   dmem_wdata_o,
   input  logic          dmem_rvalid_i,
   input  logic [31:0]   dmem_rdata_i,
   output logic          busy_mem_o,
   output logic          misaligned_mem_o,
   input  logic          stall_mem_i,
   input  logic          flush_mem_i
);

   mem_fsm_t      state_q, state_d;
   logic          valid_q, mem_req_q, we_q, unsigned_q, alu_wen_q, mem_wen_q;
   mem_size_t     size_q;
   logic [4:0]    rd_addr_q;
   reg_bank_mux_t bank_q;
   logic [31:0]   alu_result_q, wdata_q, rdata_q;
   logic          drop_q, drop_d, rdata_en;
   logic          misaligned, pending, busy, advance;
   logic [3:0]    be;
   logic [31:0]   wdata_sh, rdata_ext;

   lsu_align u_lsu_align (
      .addr_lo_i    (alu_result_q[1:0]),
      .size_i       (size_q),
      .unsigned_i   (unsigned_q),
      .wdata_i      (wdata_q),
      .rdata_i      (rdata_q),
      .be_o         (be),
      .wdata_o      (wdata_sh),
      .misaligned_o (misaligned),
      .rdata_o      (rdata_ext)
   );

   assign pending = valid_q & mem_req_q & ~misaligned;
   assign busy    = (pending && (state_q != MEM_DONE)) || drop_q;
   assign advance = ~stall_mem_i & ~busy;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q      <= 1'b0;
         mem_req_q    <= 1'b0;
         we_q         <= 1'b0;
         unsigned_q   <= 1'b0;
         alu_wen_q    <= 1'b0;
         mem_wen_q    <= 1'b0;
         size_q       <= MEM_BYTE;
         rd_addr_q    <= 5'd0;
         bank_q       <= X_REG;
         alu_result_q <= 32'd0;
         wdata_q      <= 32'd0;
      end else if (flush_mem_i) begin
         valid_q   <= 1'b0;
         mem_req_q <= 1'b0;
         alu_wen_q <= 1'b0;
         mem_wen_q <= 1'b0;
      end else if (advance) begin
         valid_q      <= valid_ex_i;
         mem_req_q    <= mem_req_ex_i;
         we_q         <= mem_we_ex_i;
         unsigned_q   <= mem_unsigned_ex_i;
         alu_wen_q    <= reg_alu_wen_ex_i;
         mem_wen_q    <= reg_mem_wen_ex_i;
         size_q       <= mem_size_ex_i;
         rd_addr_q    <= rd_addr_ex_i;
         bank_q       <= rd_dst_bank_ex_i;
         alu_result_q <= alu_result_ex_i;
         wdata_q      <= mem_wdata_ex_i;
      end
   end

   // A granted access cannot be aborted: a flush while it is outstanding only marks its response for discard.
   always_comb begin
      state_d    = state_q;
      drop_d     = drop_q;
      rdata_en   = 1'b0;
      dmem_req_o = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            dmem_req_o = pending;
            if (pending && dmem_gnt_i) begin
               state_d = MEM_WAIT_RVALID;
               drop_d  = flush_mem_i;
            end
         end
         MEM_WAIT_RVALID: begin
            if (flush_mem_i) drop_d = 1'b1;
            if (dmem_rvalid_i) begin
               rdata_en = 1'b1;
               drop_d   = 1'b0;
               state_d  = (drop_q || flush_mem_i) ? MEM_IDLE : MEM_DONE;
            end
         end
         MEM_DONE: begin
            if (!stall_mem_i || flush_mem_i) state_d = MEM_IDLE;
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= MEM_IDLE;
         drop_q  <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         if (rdata_en) rdata_q <= dmem_rdata_i;
      end
   end

   assign dmem_addr_o       = {alu_result_q[31:2], 2'b00};
   assign dmem_we_o         = we_q;
   assign dmem_be_o         = (valid_q && mem_req_q) ? be : 4'b0000;
   assign dmem_wdata_o      = wdata_sh;
   assign rd_addr_mem_o     = rd_addr_q;
   assign rd_dst_bank_mem_o = bank_q;
   assign alu_result_mem_o  = alu_result_q;
   assign mem_rdata_mem_o   = rdata_ext;
   assign misaligned_mem_o  = valid_q & mem_req_q & misaligned;
   assign busy_mem_o        = busy;
   assign valid_mem_o       = valid_q & ~busy;
   assign reg_alu_wen_mem_o = alu_wen_q & ~busy;
   assign reg_mem_wen_mem_o = mem_wen_q & ~busy & ~misaligned_mem_o;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_stage;
   import core_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [4:0]    rd_addr_ex;
   reg_bank_mux_t bank_ex;
   logic [31:0]   alu_result_ex, wdata_ex;
   logic          req_ex, we_ex, uns_ex, alu_wen_ex, mem_wen_ex, valid_ex;
   mem_size_t     size_ex;
   logic [4:0]    rd_addr_mem;
   reg_bank_mux_t bank_mem;
   logic [31:0]   alu_result_mem, rdata_mem, dmem_addr, dmem_wdata, dmem_rdata;
   logic          alu_wen_mem, mem_wen_mem, valid_mem, dmem_req, dmem_gnt, dmem_we;
   logic          dmem_rvalid, busy, misal_o, stall, flush;
   logic [3:0]    dmem_be;

   logic        auto_mode = 1'b0;
   logic        man_gnt = 1'b0, man_rvalid = 1'b0;
   logic [31:0] man_rdata = 32'd0;
   logic        auto_gnt = 1'b0, auto_rvalid = 1'b0, req_s = 1'b0;
   logic [31:0] auto_rdata = 32'd0;
   logic [1:0]  resp_cnt = 2'd0;

   assign dmem_gnt    = auto_mode ? auto_gnt    : man_gnt;
   assign dmem_rvalid = auto_mode ? auto_rvalid : man_rvalid;
   assign dmem_rdata  = auto_mode ? auto_rdata  : man_rdata;

   mem_stage dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .rd_addr_ex_i(rd_addr_ex), .rd_dst_bank_ex_i(bank_ex), .alu_result_ex_i(alu_result_ex),
      .mem_wdata_ex_i(wdata_ex), .mem_req_ex_i(req_ex), .mem_we_ex_i(we_ex),
      .mem_size_ex_i(size_ex), .mem_unsigned_ex_i(uns_ex),
      .reg_alu_wen_ex_i(alu_wen_ex), .reg_mem_wen_ex_i(mem_wen_ex), .valid_ex_i(valid_ex),
      .rd_addr_mem_o(rd_addr_mem), .rd_dst_bank_mem_o(bank_mem), .alu_result_mem_o(alu_result_mem),
      .mem_rdata_mem_o(rdata_mem), .reg_alu_wen_mem_o(alu_wen_mem), .reg_mem_wen_mem_o(mem_wen_mem),
      .valid_mem_o(valid_mem), .dmem_req_o(dmem_req), .dmem_gnt_i(dmem_gnt),
      .dmem_addr_o(dmem_addr), .dmem_we_o(dmem_we), .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
      .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
      .busy_mem_o(busy), .misaligned_mem_o(misal_o),
      .stall_mem_i(stall), .flush_mem_i(flush)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the instruction sitting in MEM plus the life of its bus transaction.
   typedef struct packed {
      logic        valid, req, we, uns, alu_wen, mem_wen, bank;
      logic [1:0]  size;
      logic [4:0]  rd;
      logic [31:0] addr, wdata;
   } instr_t;

   instr_t      m = '0;
   logic        issued = 1'b0, got_resp = 1'b0, drop_pend = 1'b0;
   logic [31:0] resp_data = 32'd0;

   function automatic logic misal_f(input instr_t i);
      return (i.size == 2'd1 && (i.addr % 2) != 0) || (i.size == 2'd2 && (i.addr % 4) != 0);
   endfunction

   function automatic logic pend_f(input instr_t i);
      return i.valid && i.req && !misal_f(i);
   endfunction

   function automatic logic busy_f(input instr_t i, input logic iss, input logic got, input logic drp);
      return (pend_f(i) && !(iss && got)) || drp;
   endfunction

   function automatic logic [31:0] load_f(input logic [31:0] d, input logic [1:0] sz, input logic u, input logic [1:0] off);
      logic [31:0] v;
      v = d >> (8 * off);
      if (sz == 2'd0) begin
         v = v & 32'hFF;
         if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = v & 32'hFFFF;
         if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [1:0] off);
      int b;
      if (sz == 2'd0)      b = 1 << off;
      else if (sz == 2'd1) b = 3 << off;
      else                 b = 15;
      return b[3:0];
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      instr_t      nm;
      logic        ni, ng, nd, b, r;
      logic [31:0] nr;
      if (!rst_n) begin
         m <= '0; issued <= 1'b0; got_resp <= 1'b0; drop_pend <= 1'b0; resp_data <= 32'd0;
      end else begin
         nm = m; ni = issued; ng = got_resp; nd = drop_pend; nr = resp_data;
         b = busy_f(m, issued, got_resp, drop_pend);
         r = pend_f(m) && !issued && !drop_pend;
         if (nd) begin
            if (dmem_rvalid) nd = 1'b0;
         end else if (ni && !ng && dmem_rvalid) begin
            ng = 1'b1;
            nr = dmem_rdata;
         end
         if (r && dmem_gnt) ni = 1'b1;
         if (flush) begin
            if (ni && !ng) nd = 1'b1;
            nm.valid = 1'b0; nm.req = 1'b0; nm.alu_wen = 1'b0; nm.mem_wen = 1'b0;
            ni = 1'b0; ng = 1'b0;
         end else if (!stall && !b) begin
            nm = '{valid: valid_ex, req: req_ex, we: we_ex, uns: uns_ex, alu_wen: alu_wen_ex,
                   mem_wen: mem_wen_ex, bank: bank_ex, size: size_ex, rd: rd_addr_ex,
                   addr: alu_result_ex, wdata: wdata_ex};
            ni = 1'b0; ng = 1'b0;
         end
         m <= nm; issued <= ni; got_resp <= ng; drop_pend <= nd; resp_data <= nr;
      end
   end

   always @(negedge clk) begin : compare
      logic eb, er, em;
      eb = busy_f(m, issued, got_resp, drop_pend);
      er = pend_f(m) && !issued && !drop_pend;
      em = m.valid && m.req && misal_f(m);
      chk1("busy", busy, eb);
      chk1("dmem_req", dmem_req, er);
      chk1("misaligned", misal_o, em);
      chk1("valid_mem", valid_mem, m.valid && !eb);
      chk1("alu_wen", alu_wen_mem, m.alu_wen && !eb);
      chk1("mem_wen", mem_wen_mem, m.mem_wen && !eb && !em);
      chk32("rd_addr", 32'(rd_addr_mem), 32'(m.rd));
      chk1("bank", bank_mem, m.bank);
      chk32("alu_result", alu_result_mem, m.addr);
      if (er) begin
         chk32("dmem_addr", dmem_addr, m.addr & 32'hFFFF_FFFC);
         chk1("dmem_we", dmem_we, m.we);
         chk32("dmem_be", 32'(dmem_be), 32'(be_f(m.size, m.addr[1:0])));
         chk32("dmem_wdata", dmem_wdata, m.wdata << (8 * m.addr[1:0]));
      end
      if (m.valid && !eb && m.req && !m.we && !em)
         chk32("load_data", rdata_mem, load_f(resp_data, m.size, m.uns, m.addr[1:0]));
   end

   // Random memory responder: grant with 2/3 probability, respond 1..3 cycles after grant.
   always @(negedge clk) begin
      req_s       <= dmem_req;
      auto_gnt    <= ($urandom % 3) != 0;
      auto_rvalid <= (resp_cnt == 2'd1);
      auto_rdata  <= $urandom;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  resp_cnt <= 2'd0;
      else if (req_s && dmem_gnt)  resp_cnt <= 2'($urandom_range(3, 1));
      else if (resp_cnt != 2'd0)   resp_cnt <= resp_cnt - 2'd1;
   end

   task automatic set_ex(input logic v, input logic rq, input logic w, input mem_size_t sz,
                         input logic u, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      valid_ex = v; req_ex = rq; we_ex = w; size_ex = sz; uns_ex = u;
      alu_result_ex = a; wdata_ex = wd; rd_addr_ex = rd;
      alu_wen_ex = !rq; mem_wen_ex = rq && !w; bank_ex = X_REG;
   endtask

   task automatic idle_ex();
      set_ex(1'b0, 1'b0, 1'b0, MEM_BYTE, 1'b0, 32'd0, 32'd0, 5'd0);
   endtask

   task automatic run_load(input string nm, input mem_size_t sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
      set_ex(1'b1, 1'b1, 1'b0, sz, u, a, 32'd0, 5'd7);
      man_gnt = 1'b1; man_rvalid = 1'b0;
      @(negedge clk);
      chk1({nm, "_busy1"}, busy, 1'b1);
      chk1({nm, "_req"}, dmem_req, 1'b1);
      chk32({nm, "_addr"}, dmem_addr, a & 32'hFFFF_FFFC);
      idle_ex();
      @(negedge clk);
      chk1({nm, "_busy2"}, busy, 1'b1);
      chk1({nm, "_req_off"}, dmem_req, 1'b0);
      man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = d;
      @(negedge clk);
      chk1({nm, "_busy3"}, busy, 1'b0);
      chk1({nm, "_wen"}, mem_wen_mem, 1'b1);
      chk32({nm, "_data"}, rdata_mem, exp);
      man_rvalid = 1'b0;
   endtask

   initial begin
      idle_ex(); stall = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_req", dmem_req, 1'b0);
      chk1("rst_valid", valid_mem, 1'b0);
      chk32("rst_be", 32'(dmem_be), 32'd0);
      chk32("rst_rdata", rdata_mem, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_load("lw",  MEM_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
      run_load("lb",  MEM_BYTE, 1'b0, 32'h103, 32'h80FF_FF7F, 32'hFFFF_FF80);
      run_load("lbu", MEM_BYTE, 1'b1, 32'h103, 32'h80FF_FF7F, 32'h0000_0080);
      run_load("lh",  MEM_HALF, 1'b0, 32'h102, 32'h8001_0000, 32'hFFFF_8001);

      // sb with grant withheld three cycles
      set_ex(1'b1, 1'b1, 1'b1, MEM_BYTE, 1'b0, 32'h201, 32'h0000_00AB, 5'd3);
      man_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle_ex();
         chk1("sb_req", dmem_req, 1'b1);
         chk32("sb_addr", dmem_addr, 32'h200);
         chk32("sb_be", 32'(dmem_be), 32'h2);
         chk32("sb_wdata", dmem_wdata, 32'h0000_AB00);
         chk1("sb_we", dmem_we, 1'b1);
      end
      man_gnt = 1'b1;
      @(negedge clk);
      man_gnt = 1'b0; man_rvalid = 1'b1;
      @(negedge clk);
      man_rvalid = 1'b0;
      chk1("sb_done_busy", busy, 1'b0);
      chk1("sb_done_valid", valid_mem, 1'b1);

      // misaligned lw
      set_ex(1'b1, 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h102, 32'd0, 5'd4);
      @(negedge clk);
      idle_ex();
      chk1("mis_flag", misal_o, 1'b1);
      chk1("mis_req", dmem_req, 1'b0);
      chk1("mis_wen", mem_wen_mem, 1'b0);
      chk1("mis_busy", busy, 1'b0);

      // flush while waiting for rvalid
      set_ex(1'b1, 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h300, 32'd0, 5'd9);
      man_gnt = 1'b1;
      @(negedge clk);
      idle_ex();
      @(negedge clk);
      man_gnt = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk1("fl_busy1", busy, 1'b1);
      chk1("fl_valid1", valid_mem, 1'b0);
      @(negedge clk);
      chk1("fl_busy2", busy, 1'b1);
      man_rvalid = 1'b1; man_rdata = 32'h1234_5678;
      @(negedge clk);
      man_rvalid = 1'b0;
      chk1("fl_busy3", busy, 1'b0);
      chk1("fl_valid3", valid_mem, 1'b0);
      chk1("fl_wen3", mem_wen_mem, 1'b0);
      run_load("after_fl", MEM_WORD, 1'b0, 32'h310, 32'hCAFE_F00D, 32'hCAFE_F00D);

      // two loads, stall one cycle in DONE
      set_ex(1'b1, 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h400, 32'd0, 5'd1);
      man_gnt = 1'b1;
      @(negedge clk);
      set_ex(1'b1, 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h404, 32'd0, 5'd2);
      @(negedge clk);
      man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h1111_2222;
      @(negedge clk);
      man_rvalid = 1'b0; stall = 1'b1;
      chk32("b2b_d1", rdata_mem, 32'h1111_2222);
      @(negedge clk);
      stall = 1'b0;
      chk32("b2b_d1_held", rdata_mem, 32'h1111_2222);
      chk1("b2b_req_held_off", dmem_req, 1'b0);
      @(negedge clk);
      idle_ex(); man_gnt = 1'b1;
      chk1("b2b_req2", dmem_req, 1'b1);
      chk32("b2b_addr2", dmem_addr, 32'h404);
      @(negedge clk);
      man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h3333_4444;
      @(negedge clk);
      man_rvalid = 1'b0;
      chk32("b2b_d2", rdata_mem, 32'h3333_4444);

      // randomized traffic with one asynchronous reset in the middle
      auto_mode = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         set_ex(($urandom % 5) != 0, 1'($urandom % 2), 1'($urandom % 2),
                mem_size_t'(2'($urandom % 3)), 1'($urandom % 2), $urandom, $urandom, 5'($urandom));
         bank_ex = reg_bank_mux_t'(1'($urandom % 2));
         stall = ($urandom % 5) == 0;
         flush = ($urandom % 20) == 0;
         if (i == 2000) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            chk1("mid_rst_busy", busy, 1'b0);
            chk1("mid_rst_req", dmem_req, 1'b0);
            chk1("mid_rst_valid", valid_mem, 1'b0);
            #2 rst_n = 1'b1;
         end
      end
      @(negedge clk);
      idle_ex(); stall = 1'b0; flush = 1'b0;
      repeat (10) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
